// File: rtl/sr_latch_driver_pkg.sv
// Shared types for the sr_latch command sequencer: FSM state encoding and
// command op-codes.
package sr_latch_driver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } sr_drv_state_t;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_SET = 2'b01;
  localparam logic [1:0] OP_RST = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  // Only set and reset actually touch the latch.
  function automatic logic op_is_write(input logic [1:0] op);
    return (op == OP_SET) || (op == OP_RST);
  endfunction

endpackage

// File: rtl/sr_drv_phase_cnt.sv
// Loadable down-counter timing each drive phase; zero marks the last cycle
// of the current phase.
module sr_drv_phase_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sr_latch_driver.sv
// Command sequencer driving sr_latch s/r/en through setup, enable-pulse and
// hold phases. Define SR_LATCH_DRIVER_READBACK_EN to check q after each write.
module sr_latch_driver
  import sr_latch_driver_pkg::*;
#(
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  // Handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both high; the source holds cmd_valid/cmd_op until then.
  input  logic       cmd_valid,
  input  logic [1:0] cmd_op,
  output logic       cmd_ready,
  output logic       s,
  output logic       r,
  output logic       en,
  input  logic       q_in,
  output logic       done,
  output logic       err
);

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

  sr_drv_state_t    state;
  logic [1:0]       op_q;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;
  logic             rb_err;

  // Each phase loads its length-1 on the edge that enters it.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    unique case (state)
      ST_IDLE: begin
        if (cmd_valid && op_is_write(cmd_op)) begin
          cnt_load = 1'b1;
          cnt_val  = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = PULSE_LD;
        end
      end
      ST_PULSE: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = HOLD_LD;
        end
      end
      default: ;
    endcase
  end

  sr_drv_phase_cnt #(
    .CNT_W(CNT_W)
  ) u_phase_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (cnt_load),
    .load_val(cnt_val),
    .zero    (cnt_zero)
  );

`ifdef SR_LATCH_DRIVER_READBACK_EN
  // q_in is captured on the HOLD->DONE edge, i.e. as seen in the last HOLD
  // cycle, straight into the err register.
  assign rb_err = (q_in != (op_q == OP_SET));
`else
  logic unused_q_in;
  assign unused_q_in = q_in;
  assign rb_err      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_q      <= OP_NOP;
      cmd_ready <= 1'b1;
      s         <= 1'b0;
      r         <= 1'b0;
      en        <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q      <= cmd_op;
            cmd_ready <= 1'b0;
            if (op_is_write(cmd_op)) begin
              state <= ST_SETUP;
              s     <= (cmd_op == OP_SET);
              r     <= (cmd_op == OP_RST);
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
              err   <= (cmd_op == OP_ILL);
            end
          end
        end
        ST_SETUP: begin
          if (cnt_zero) begin
            state <= ST_PULSE;
            en    <= 1'b1;
          end
        end
        ST_PULSE: begin
          if (cnt_zero) begin
            state <= ST_HOLD;
            en    <= 1'b0;
          end
        end
        ST_HOLD: begin
          // s/r drop only now, with en already low for the whole hold time.
          if (cnt_zero) begin
            state <= ST_DONE;
            s     <= 1'b0;
            r     <= 1'b0;
            done  <= 1'b1;
            err   <= rb_err;
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          done      <= 1'b0;
          err       <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: default instance plus a 3/1/2 phase instance,
// each driving a behavioural sr_latch model.
module tb_sr_latch_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] cmd_valid = '0;
  logic [1:0] cmd_op0 = '0;
  logic [1:0] cmd_op1 = '0;
  logic [1:0] cmd_ready, s, r, en, done, err, q_in;
  logic [1:0] q_lat = '0;
  logic [1:0] q_force = '0;
  logic [1:0] prev_sr [2];

  int sc [2] = '{1, 3};
  int pc [2] = '{2, 1};
  int hc [2] = '{1, 2};

  int n_checks = 0;
  int n_pass = 0;

  logic [0:0] exp_q0 [$];
  logic [0:0] exp_q1 [$];

  always #5 clk = ~clk;

  sr_latch_driver u_dut0 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[0]), .cmd_op(cmd_op0),
    .cmd_ready(cmd_ready[0]), .s(s[0]), .r(r[0]), .en(en[0]), .q_in(q_in[0]),
    .done(done[0]), .err(err[0])
  );

  sr_latch_driver #(.SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(2), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[1]), .cmd_op(cmd_op1),
    .cmd_ready(cmd_ready[1]), .s(s[1]), .r(r[1]), .en(en[1]), .q_in(q_in[1]),
    .done(done[1]), .err(err[1])
  );

  // Latch model: transparent while en; inputs only move on rising edges.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (en[k]) begin
        if (s[k]) q_lat[k] = 1'b1;
        else if (r[k]) q_lat[k] = 1'b0;
      end
    end
  end

  assign q_in = q_lat & ~q_force;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Invariants and done/err scoreboard, every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("no_s_and_r%0d", k), {7'd0, s[k] & r[k]}, 8'd0);
        if (en[k]) chk($sformatf("sr_stable_en%0d", k), {6'd0, s[k], r[k]}, {6'd0, prev_sr[k]});
      end
      if (done[0]) begin
        chk("done0_expected", {7'd0, exp_q0.size() != 0}, 8'd1);
        if (exp_q0.size() != 0) chk("err0", {7'd0, err[0]}, {7'd0, exp_q0.pop_front()});
      end
      if (done[1]) begin
        chk("done1_expected", {7'd0, exp_q1.size() != 0}, 8'd1);
        if (exp_q1.size() != 0) chk("err1", {7'd0, err[1]}, {7'd0, exp_q1.pop_front()});
      end
    end
    for (int k = 0; k < 2; k++) prev_sr[k] = {s[k], r[k]};
  end

  // Expected {s, r, en, done, cmd_ready} o cycles after the accepting edge.
  function automatic logic [4:0] exp_at(input int k, input logic [1:0] op, input int o);
    bit wr;
    int l;
    bit drive;
    wr    = (op == 2'b01) || (op == 2'b10);
    l     = wr ? sc[k] + pc[k] + hc[k] + 1 : 1;
    drive = wr && (o >= 1) && (o <= l - 1);
    return {drive && op == 2'b01, drive && op == 2'b10,
            wr && (o > sc[k]) && (o <= sc[k] + pc[k]), o == l, o > l};
  endfunction

  task automatic do_cmd(input int k, input logic [1:0] op, input logic frc);
    bit   wr;
    int   l;
    logic e_err;
    wr    = (op == 2'b01) || (op == 2'b10);
    l     = wr ? sc[k] + pc[k] + hc[k] + 1 : 1;
    e_err = (op == 2'b11);
`ifdef SR_LATCH_DRIVER_READBACK_EN
    if (wr) e_err = ((frc ? 1'b0 : (op == 2'b01)) != (op == 2'b01));
`endif
    chk($sformatf("ready_pre%0d", k), {7'd0, cmd_ready[k]}, 8'd1);
    if (k == 0) begin exp_q0.push_back(e_err); cmd_op0 = op; end
    else begin exp_q1.push_back(e_err); cmd_op1 = op; end
    cmd_valid[k] = 1'b1;
    q_force[k]   = frc;
    @(negedge clk);
    cmd_valid[k] = 1'b0;
    for (int o = 1; o <= l + 1; o++) begin
      chk($sformatf("trace%0d_op%0d_o%0d", k, op, o),
          {3'd0, s[k], r[k], en[k], done[k], cmd_ready[k]}, {3'd0, exp_at(k, op, o)});
      if (o <= l) @(negedge clk);
    end
    q_force[k] = 1'b0;
    if (wr && !frc) chk($sformatf("q%0d_after_op%0d", k, op), {7'd0, q_lat[k]}, {7'd0, op == 2'b01});
  endtask

  initial begin
    int a0, a1, acc;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_outs0", {2'd0, cmd_ready[0], s[0], r[0], en[0], done[0], err[0]}, 8'b0010_0000);
    chk("reset_outs1", {2'd0, cmd_ready[1], s[1], r[1], en[1], done[1], err[1]}, 8'b0010_0000);

    // Set, then reset with the command held valid through the busy period.
    do_cmd(0, 2'b01, 1'b0);
    acc = 0; a0 = -1; a1 = -1;
    exp_q0.push_back(1'b0);
    exp_q0.push_back(1'b0);
    cmd_op0 = 2'b01;
    cmd_valid[0] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (cmd_valid[0] && cmd_ready[0]) begin
        if (acc == 0) a0 = i; else a1 = i;
        acc++;
      end
      @(negedge clk);
      if (i == 0) cmd_op0 = 2'b10;
    end
    cmd_valid[0] = 1'b0;
    chk("b2b_accepts", acc[7:0], 8'd2);
    chk("b2b_spacing", 8'(a1 - a0), 8'd6);
    chk("b2b_q_reset", {7'd0, q_lat[0]}, 8'd0);
    chk("b2b_ready", {7'd0, cmd_ready[0]}, 8'd1);

    do_cmd(0, 2'b00, 1'b0);
    do_cmd(0, 2'b11, 1'b0);
    do_cmd(0, 2'b01, 1'b1);
    do_cmd(0, 2'b10, 1'b0);

    // Reset mid-PULSE.
    cmd_op0 = 2'b01;
    cmd_valid[0] = 1'b1;
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    for (int i = 0; i < 10 && !en[0]; i++) @(negedge clk);
    chk("pulse_reached", {7'd0, en[0]}, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outs", {4'd0, s[0], r[0], en[0], done[0]}, 8'd0);
    exp_q0.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {7'd0, cmd_ready[0]}, 8'd1);
    chk("q_kept_after_reset", {7'd0, q_lat[0]}, 8'd1);
    do_cmd(0, 2'b10, 1'b0);

    // Stretched phases, then random traffic on both instances.
    do_cmd(1, 2'b01, 1'b0);
    do_cmd(1, 2'b01, 1'b1);
    for (int n = 0; n < 100; n++) begin
      do_cmd(1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    for (int n = 0; n < 30; n++) begin
      do_cmd(0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    chk("sb0_empty", 8'(exp_q0.size()), 8'd0);
    chk("sb1_empty", 8'(exp_q1.size()), 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
